// File: rtl/dsp_mac_nch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dsp_mac_nch
// Purpose  : Channel-interleaved pre-add / multiply / post-add MAC slice with
//            a per-channel accumulator bank and optional saturation.
// Revision : 1.0  initial release
// ============================================================================
module dsp_mac_nch #(
    parameter int A_WIDTH     = 18,
    parameter int B_WIDTH     = 18,
    parameter int C_WIDTH     = 48,
    parameter int P_WIDTH     = 48,
    parameter int CHANNELS    = 4,
    parameter int MREG_STAGES = 2,
    parameter int SATURATE    = 1,
    localparam int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ce,
    input  logic                      in_valid,
    input  logic [CW-1:0]             in_ch,
    input  logic signed [A_WIDTH-1:0] a,
    input  logic signed [B_WIDTH-1:0] b,
    input  logic signed [B_WIDTH-1:0] d,
    input  logic signed [C_WIDTH-1:0] c,
    input  logic                      preadd_en,
    input  logic                      preadd_sub,
    input  logic                      post_sub,
    input  logic [1:0]                zsel,
    input  logic                      carryin,
    input  logic                      acc_clr_all,
    output logic                      out_valid,
    output logic [CW-1:0]             out_ch,
    output logic signed [P_WIDTH-1:0] p,
    output logic                      ovf
);

    localparam int c_pre_w  = B_WIDTH + 1;
    localparam int c_prod_w = A_WIDTH + B_WIDTH + 1;
    localparam int c_sum_w  = P_WIDTH + 2;
    localparam int c_last   = MREG_STAGES - 1;

    // input register stage
    logic signed [A_WIDTH-1:0] r1_a;
    logic signed [B_WIDTH-1:0] r1_b, r1_d;
    logic signed [C_WIDTH-1:0] r1_c;
    logic                      r1_pre_en, r1_pre_sub, r1_post_sub, r1_cin, r1_vld;
    logic [1:0]                r1_zsel;
    logic [CW-1:0]             r1_ch;

    // pre-adder register stage
    logic signed [A_WIDTH-1:0] r2_a;
    logic signed [c_pre_w-1:0] r2_pre;
    logic signed [C_WIDTH-1:0] r2_c;
    logic                      r2_post_sub, r2_cin, r2_vld;
    logic [1:0]                r2_zsel;
    logic [CW-1:0]             r2_ch;

    // product register stages
    logic signed [c_prod_w-1:0] r_m_prod [MREG_STAGES];
    logic signed [C_WIDTH-1:0]  r_m_c    [MREG_STAGES];
    logic                       r_m_sub  [MREG_STAGES];
    logic                       r_m_cin  [MREG_STAGES];
    logic                       r_m_vld  [MREG_STAGES];
    logic [1:0]                 r_m_zsel [MREG_STAGES];
    logic [CW-1:0]              r_m_ch   [MREG_STAGES];

    logic signed [P_WIDTH-1:0] r_p;
    logic                      r_ovf, r_out_vld;
    logic [CW-1:0]             r_out_ch;
    logic signed [P_WIDTH-1:0] r_bank [CHANNELS];

    logic signed [c_pre_w-1:0]  w_b_ext, w_d_ext, w_pre;
    logic signed [c_prod_w-1:0] w_a_ext, w_pre_ext, w_prod;
    logic signed [P_WIDTH-1:0]  w_bank_rd;
    logic signed [c_sum_w-1:0]  w_x, w_z, w_cin, w_sum;
    logic [2:0]                 w_top;
    logic                       w_ovf;
    logic signed [P_WIDTH-1:0]  w_res;

    always_comb begin
        w_b_ext = {r1_b[B_WIDTH-1], r1_b};
        w_d_ext = {r1_d[B_WIDTH-1], r1_d};
        w_pre   = w_b_ext;
        if (r1_pre_en) begin
            w_pre = r1_pre_sub ? (w_d_ext - w_b_ext) : (w_d_ext + w_b_ext);
        end
    end

    // operands widened to full product width so the multiply is exact
    always_comb begin
        w_a_ext   = {{(c_prod_w-A_WIDTH){r2_a[A_WIDTH-1]}}, r2_a};
        w_pre_ext = {{(c_prod_w-c_pre_w){r2_pre[c_pre_w-1]}}, r2_pre};
        w_prod    = w_a_ext * w_pre_ext;
    end

    // out-of-range channels match no entry and read back as zero
    always_comb begin
        w_bank_rd = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_m_ch[c_last] == CW'(i)) begin
                w_bank_rd = r_bank[i];
            end
        end
    end

    always_comb begin
        w_x   = {{(c_sum_w-c_prod_w){r_m_prod[c_last][c_prod_w-1]}}, r_m_prod[c_last]};
        w_cin = {{(c_sum_w-1){1'b0}}, r_m_cin[c_last]};
        case (r_m_zsel[c_last])
            2'd1:    w_z = {{2{w_bank_rd[P_WIDTH-1]}}, w_bank_rd};
            2'd2:    w_z = {{(c_sum_w-C_WIDTH){r_m_c[c_last][C_WIDTH-1]}}, r_m_c[c_last]};
            default: w_z = '0;
        endcase
        w_sum = r_m_sub[c_last] ? (w_z - (w_x + w_cin)) : (w_z + w_x + w_cin);
        w_top = w_sum[c_sum_w-1:P_WIDTH-1];
        w_ovf = !((&w_top) || (~|w_top));
        w_res = w_sum[P_WIDTH-1:0];
        if (w_ovf && (SATURATE != 0)) begin
            w_res = w_sum[c_sum_w-1] ? {1'b1, {(P_WIDTH-1){1'b0}}}
                                     : {1'b0, {(P_WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_a <= '0; r1_b <= '0; r1_d <= '0; r1_c <= '0;
            r1_pre_en <= 1'b0; r1_pre_sub <= 1'b0; r1_post_sub <= 1'b0;
            r1_cin <= 1'b0; r1_vld <= 1'b0; r1_zsel <= '0; r1_ch <= '0;
            r2_a <= '0; r2_pre <= '0; r2_c <= '0; r2_post_sub <= 1'b0;
            r2_cin <= 1'b0; r2_vld <= 1'b0; r2_zsel <= '0; r2_ch <= '0;
            for (int i = 0; i < MREG_STAGES; i++) begin
                r_m_prod[i] <= '0; r_m_c[i] <= '0; r_m_sub[i] <= 1'b0;
                r_m_cin[i] <= 1'b0; r_m_vld[i] <= 1'b0; r_m_zsel[i] <= '0;
                r_m_ch[i] <= '0;
            end
            r_p <= '0; r_ovf <= 1'b0; r_out_vld <= 1'b0; r_out_ch <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_bank[i] <= '0;
            end
        end else if (ce) begin
            r1_a <= a; r1_b <= b; r1_d <= d; r1_c <= c;
            r1_pre_en <= preadd_en; r1_pre_sub <= preadd_sub; r1_post_sub <= post_sub;
            r1_cin <= carryin; r1_vld <= in_valid; r1_zsel <= zsel; r1_ch <= in_ch;

            r2_a <= r1_a; r2_pre <= w_pre; r2_c <= r1_c; r2_post_sub <= r1_post_sub;
            r2_cin <= r1_cin; r2_vld <= r1_vld; r2_zsel <= r1_zsel; r2_ch <= r1_ch;

            r_m_prod[0] <= w_prod; r_m_c[0] <= r2_c; r_m_sub[0] <= r2_post_sub;
            r_m_cin[0] <= r2_cin; r_m_vld[0] <= r2_vld; r_m_zsel[0] <= r2_zsel;
            r_m_ch[0] <= r2_ch;
            for (int i = 1; i < MREG_STAGES; i++) begin
                r_m_prod[i] <= r_m_prod[i-1]; r_m_c[i] <= r_m_c[i-1];
                r_m_sub[i] <= r_m_sub[i-1]; r_m_cin[i] <= r_m_cin[i-1];
                r_m_vld[i] <= r_m_vld[i-1]; r_m_zsel[i] <= r_m_zsel[i-1];
                r_m_ch[i] <= r_m_ch[i-1];
            end

            // bubbles leave P, channel and flag untouched
            r_out_vld <= r_m_vld[c_last];
            if (r_m_vld[c_last]) begin
                r_p      <= w_res;
                r_ovf    <= w_ovf;
                r_out_ch <= r_m_ch[c_last];
            end

            // a clear overrides the same-cycle accumulator write
            for (int i = 0; i < CHANNELS; i++) begin
                if (acc_clr_all) begin
                    r_bank[i] <= '0;
                end else if (r_m_vld[c_last] && (r_m_ch[c_last] == CW'(i))) begin
                    r_bank[i] <= w_res;
                end
            end
        end
    end

    assign out_valid = r_out_vld;
    assign out_ch    = r_out_ch;
    assign p         = r_p;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_nch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dsp_mac_nch
// Purpose  : Scoreboard bench; a saturating 4-channel and a wrapping 3-channel
//            instance share one stimulus stream.
// Revision : 1.0  initial release
// ============================================================================
module tb_dsp_mac_nch;

    localparam longint c_pmax = (64'sd1 <<< 47) - 64'sd1;
    localparam longint c_pmin = -(64'sd1 <<< 47);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               ce = 1'b1;
    logic               in_valid = 1'b0;
    logic [1:0]         in_ch = '0;
    logic signed [17:0] a = '0, b = '0, d = '0;
    logic signed [47:0] c = '0;
    logic               preadd_en = 1'b0, preadd_sub = 1'b0, post_sub = 1'b0;
    logic [1:0]         zsel = '0;
    logic               carryin = 1'b0, acc_clr_all = 1'b0;

    logic               ov_s, of_s, ov_w, of_w;
    logic [1:0]         ch_s, ch_w;
    logic signed [47:0] p_s, p_w;

    dsp_mac_nch #(.A_WIDTH(18), .B_WIDTH(18), .C_WIDTH(48), .P_WIDTH(48),
                  .CHANNELS(4), .MREG_STAGES(2), .SATURATE(1)) u_dut_sat (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_ch(in_ch),
        .a(a), .b(b), .d(d), .c(c), .preadd_en(preadd_en), .preadd_sub(preadd_sub),
        .post_sub(post_sub), .zsel(zsel), .carryin(carryin), .acc_clr_all(acc_clr_all),
        .out_valid(ov_s), .out_ch(ch_s), .p(p_s), .ovf(of_s));

    dsp_mac_nch #(.A_WIDTH(18), .B_WIDTH(18), .C_WIDTH(48), .P_WIDTH(48),
                  .CHANNELS(3), .MREG_STAGES(2), .SATURATE(0)) u_dut_wrap (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_ch(in_ch),
        .a(a), .b(b), .d(d), .c(c), .preadd_en(preadd_en), .preadd_sub(preadd_sub),
        .post_sub(post_sub), .zsel(zsel), .carryin(carryin), .acc_clr_all(acc_clr_all),
        .out_valid(ov_w), .out_ch(ch_w), .p(p_w), .ovf(of_w));

    always #5 clk = ~clk;

    typedef struct {
        longint ps;
        longint pw;
        bit     os;
        bit     ow;
        int     ch;
        int     tick;
    } exp_t;

    exp_t   r_q [$];
    longint r_bank_s [4];
    longint r_bank_w [4];
    int     r_tick = 0;
    logic   r_ce_q = 1'b0;
    int     n_tests = 0;
    int     n_fail = 0;
    exp_t   r_e;
    bit     r_ev;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void post_add(input longint z, input longint x, input bit ci,
                                     input bit sub, input bit sat,
                                     output longint res, output bit o);
        longint s;
        logic [63:0] t;
        s = sub ? (z - (x + longint'(ci))) : (z + x + longint'(ci));
        o = (s > c_pmax) || (s < c_pmin);
        t = s;
        if (o && sat) res = (s > c_pmax) ? c_pmax : c_pmin;
        else          res = longint'($signed(t[47:0]));
    endfunction

    task automatic clr_bank();
        for (int i = 0; i < 4; i++) begin
            r_bank_s[i] = 0;
            r_bank_w[i] = 0;
        end
    endtask

    // drive one cycle of stimulus; captured samples are modelled and queued
    task automatic smp(input bit v, input int ch, input int av, input int bv, input int dv,
                       input longint cv, input bit pe, input bit ps, input bit qs,
                       input int zs, input bit ci);
        longint pre, x, z_s, z_w, rs, rw;
        bit     os, ow;
        exp_t   e;
        in_valid = v; in_ch = 2'(ch); a = 18'(av); b = 18'(bv); d = 18'(dv);
        c = 48'(cv); preadd_en = pe; preadd_sub = ps; post_sub = qs;
        zsel = 2'(zs); carryin = ci;
        if (v && ce) begin
            pre = pe ? (ps ? longint'(dv) - longint'(bv) : longint'(dv) + longint'(bv))
                     : longint'(bv);
            x   = longint'(av) * pre;
            z_s = (zs == 1) ? r_bank_s[ch] : ((zs == 2) ? cv : 0);
            z_w = (zs == 1 && ch < 3) ? r_bank_w[ch] : ((zs == 2) ? cv : 0);
            post_add(z_s, x, ci, qs, 1'b1, rs, os);
            post_add(z_w, x, ci, qs, 1'b0, rw, ow);
            r_bank_s[ch] = rs;
            if (ch < 3) r_bank_w[ch] = rw;
            e.ps = rs; e.pw = rw; e.os = os; e.ow = ow; e.ch = ch;
            e.tick = r_tick + 5;
            r_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) smp(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    always @(posedge clk) begin
        if (ce) r_tick <= r_tick + 1;
        r_ce_q <= ce;
    end

    // outputs are only new after an enabled edge
    always @(negedge clk) begin
        if (!rst && r_ce_q) begin
            r_ev = (r_q.size() > 0) && (r_q[0].tick == r_tick);
            chk("out_valid_sat", ov_s, r_ev);
            chk("out_valid_wrap", ov_w, r_ev);
            if (r_ev) begin
                r_e = r_q.pop_front();
                chk("p_sat", p_s, r_e.ps);
                chk("p_wrap", p_w, r_e.pw);
                chk("ovf_sat", of_s, r_e.os);
                chk("ovf_wrap", of_w, r_e.ow);
                chk("out_ch_sat", ch_s, r_e.ch);
                chk("out_ch_wrap", ch_w, r_e.ch);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_bank();
        repeat (3) @(negedge clk);
        chk("rst_p", p_s, 0);
        chk("rst_valid", ov_s, 0);
        chk("rst_ch", ch_s, 0);
        chk("rst_ovf", of_s, 0);
        chk("rst_p_wrap", p_w, 0);
        rst = 1'b0;
        idle(2);

        // pre-adder add then subtract
        smp(1, 0, 3, 20, 100, 0, 1, 0, 0, 0, 0);
        smp(1, 0, -2, 20, 5, 0, 1, 1, 0, 0, 0);
        idle(6);

        // round-robin accumulation
        for (int pass = 0; pass < 3; pass++)
            for (int k = 0; k < 4; k++)
                smp(1, k, k + 1, 1, 0, 0, 0, 0, 0, 1, 0);
        idle(6);
        acc_clr_all = 1'b1;
        idle(1);
        acc_clr_all = 1'b0;
        clr_bank();
        for (int i = 0; i < 5; i++) smp(1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0);
        idle(6);

        // overflow at the positive bound, then an in-range result
        smp(1, 1, 1, 1, 0, c_pmax, 0, 0, 0, 2, 0);
        smp(1, 1, 1, 1, 0, 5, 0, 0, 0, 2, 0);
        smp(1, 1, -1, 1, 0, c_pmin, 0, 0, 0, 2, 0);
        idle(6);

        // post-subtract with carry, then per-sample control toggling
        smp(1, 2, 10, 10, 0, 1000, 0, 0, 1, 2, 1);
        for (int i = 0; i < 6; i++)
            smp(1, i % 4, 7 + i, 3, 50, 200, 1, i[0], ~i[0], 2, i[1]);
        idle(6);

        // mixed stream with a three-cycle stall in the middle
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                ce = 1'b0;
                repeat (3) smp(1, 1, 99, 99, 0, 0, 0, 0, 0, 1, 0);
                ce = 1'b1;
            end
            smp(1, i % 4, int'($urandom_range(0, 2000)) - 1000,
                int'($urandom_range(0, 200)) - 100, int'($urandom_range(0, 200)),
                longint'($urandom_range(0, 100000)) - 50000,
                i[0], i[1], i[2], i % 4, i[0]);
        end
        idle(6);

        // clear coinciding with a channel-2 accumulator write
        smp(1, 2, 4, 5, 0, 0, 0, 0, 0, 1, 0);
        idle(3);
        acc_clr_all = 1'b1;
        idle(1);
        acc_clr_all = 1'b0;
        clr_bank();
        smp(1, 2, 6, 7, 0, 0, 0, 0, 0, 1, 0);
        idle(6);

        // asynchronous reset mid-stream
        for (int i = 0; i < 6; i++) smp(1, i % 4, i + 2, 3, 0, 0, 0, 0, 0, 1, 0);
        #2;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("async_rst_p", p_s, 0);
        chk("async_rst_valid", ov_s, 0);
        chk("async_rst_p_wrap", p_w, 0);
        chk("async_rst_valid_wrap", ov_w, 0);
        r_q.delete();
        clr_bank();
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        for (int pass = 0; pass < 2; pass++)
            for (int k = 0; k < 4; k++)
                smp(1, k, k + 1, 2, 0, 0, 0, 0, 0, 1, 0);
        idle(8);

        chk("queue_drained", r_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
